// File: rtl/audio_stream_proc_if.sv
// rtl/audio_stream_proc_if.sv - codec read/write FIFO handshake bundle for audio_stream_proc
interface audio_stream_proc_if #(
  parameter int DATA_W = 24
);
  logic              read_ready;
  logic              write_ready;
  logic [DATA_W-1:0] readdata_left;
  logic [DATA_W-1:0] readdata_right;
  logic              read;
  logic              write;
  logic [DATA_W-1:0] writedata_left;
  logic [DATA_W-1:0] writedata_right;

  modport master (
    input  read_ready, write_ready, readdata_left, readdata_right,
    output read, write, writedata_left, writedata_right
  );

  modport slave (
    output read_ready, write_ready, readdata_left, readdata_right,
    input  read, write, writedata_left, writedata_right
  );
endinterface

// File: rtl/audio_stream_proc.sv
// rtl/audio_stream_proc.sv - per-sample codec processor: pass/swap/mono/echo with circular delay line
// Define AUDIO_SAT_EN to saturate the echo sum instead of wrapping it.
module audio_stream_proc #(
  parameter int DATA_W      = 24,
  parameter int DEPTH       = 2048,
  parameter int ATTEN_SHIFT = 1
) (
  input  logic                  CLOCK_50,
  input  logic                  reset,
  input  logic [1:0]            mode,
  audio_stream_proc_if.master   codec,
  output logic                  delay_full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_CALC, S_WRITE} state_t;

  state_t                    state_q;
  logic [1:0]                mode_q;
  logic [PTR_W-1:0]          wr_ptr_q;
  logic [CNT_W-1:0]          fill_q;
  logic                      full_q;
  logic                      read_q;
  logic                      write_q;
  logic signed [DATA_W-1:0]  in_l_q, in_r_q;
  logic signed [DATA_W-1:0]  out_l_q, out_r_q;
  logic [2*DATA_W-1:0]       mem_q [DEPTH];
  logic [2*DATA_W-1:0]       mem_rd_q;

  logic signed [DATA_W-1:0]  dly_l, dly_r;
  logic signed [DATA_W-1:0]  out_l_d, out_r_d;
`ifdef AUDIO_SAT_EN
  logic signed [DATA_W:0]    echo_l, echo_r;
`endif

  // History only counts once a full DEPTH of samples has been written.
  assign dly_l = full_q ? $signed(mem_rd_q[2*DATA_W-1:DATA_W]) : '0;
  assign dly_r = full_q ? $signed(mem_rd_q[DATA_W-1:0])        : '0;

  always_comb begin
    out_l_d = in_l_q;
    out_r_d = in_r_q;
`ifdef AUDIO_SAT_EN
    echo_l = $signed({in_l_q[DATA_W-1], in_l_q}) + (DATA_W+1)'(dly_l >>> ATTEN_SHIFT);
    echo_r = $signed({in_r_q[DATA_W-1], in_r_q}) + (DATA_W+1)'(dly_r >>> ATTEN_SHIFT);
`endif
    case (mode_q)
      2'd1: begin
        out_l_d = in_r_q;
        out_r_d = in_l_q;
      end
      2'd2: begin
        out_l_d = DATA_W'(($signed({in_l_q[DATA_W-1], in_l_q}) +
                           $signed({in_r_q[DATA_W-1], in_r_q})) >>> 1);
        out_r_d = out_l_d;
      end
      2'd3: begin
`ifdef AUDIO_SAT_EN
        if (echo_l[DATA_W] != echo_l[DATA_W-1])
          out_l_d = echo_l[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
        else
          out_l_d = echo_l[DATA_W-1:0];
        if (echo_r[DATA_W] != echo_r[DATA_W-1])
          out_r_d = echo_r[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
        else
          out_r_d = echo_r[DATA_W-1:0];
`else
        out_l_d = in_l_q + (dly_l >>> ATTEN_SHIFT);
        out_r_d = in_r_q + (dly_r >>> ATTEN_SHIFT);
`endif
      end
      default: begin
        out_l_d = in_l_q;
        out_r_d = in_r_q;
      end
    endcase
  end

  // Delay line is written in every mode so echo has valid history on entry.
  always_ff @(posedge CLOCK_50) begin
    if (state_q == S_READ)
      mem_rd_q <= mem_q[wr_ptr_q];
    if (state_q == S_CALC)
      mem_q[wr_ptr_q] <= {in_l_q, in_r_q};
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q  <= S_IDLE;
      mode_q   <= 2'd0;
      wr_ptr_q <= '0;
      fill_q   <= '0;
      full_q   <= 1'b0;
      read_q   <= 1'b0;
      write_q  <= 1'b0;
      in_l_q   <= '0;
      in_r_q   <= '0;
      out_l_q  <= '0;
      out_r_q  <= '0;
    end else begin
      read_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          mode_q  <= mode;
          write_q <= 1'b0;
          if (codec.read_ready && codec.write_ready) begin
            state_q <= S_READ;
            read_q  <= 1'b1;
          end
        end
        S_READ: begin
          in_l_q  <= codec.readdata_left;
          in_r_q  <= codec.readdata_right;
          state_q <= S_CALC;
        end
        S_CALC: begin
          out_l_q  <= out_l_d;
          out_r_q  <= out_r_d;
          wr_ptr_q <= (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
          if (fill_q != CNT_W'(DEPTH))
            fill_q <= fill_q + 1'b1;
          if (fill_q == CNT_W'(DEPTH - 1))
            full_q <= 1'b1;
          // Strobe lands in the first S_WRITE cycle when the codec is already ready.
          write_q  <= codec.write_ready;
          state_q  <= S_WRITE;
        end
        S_WRITE: begin
          if (write_q) begin
            write_q <= 1'b0;
            state_q <= S_IDLE;
          end else if (codec.write_ready) begin
            write_q <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign codec.read            = read_q;
  assign codec.write           = write_q;
  assign codec.writedata_left  = out_l_q;
  assign codec.writedata_right = out_r_q;
  assign delay_full            = full_q;

endmodule

// File: tb/tb_audio_stream_proc.sv
// tb/tb_audio_stream_proc.sv - directed vector bench for audio_stream_proc (DEPTH=4, ATTEN_SHIFT=1)
module tb_audio_stream_proc;
  localparam int DW    = 24;
  localparam int DEPTH = 4;

`ifdef AUDIO_SAT_EN
  localparam logic [DW-1:0] E_OVF_L = 24'h7FFFFF;
  localparam logic [DW-1:0] E_OVF_R = 24'h800000;
`else
  localparam logic [DW-1:0] E_OVF_L = 24'hBFFFFE;
  localparam logic [DW-1:0] E_OVF_R = 24'h400000;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] mode = 2'd0;
  logic       delay_full;
  int         errors = 0;
  int         checks = 0;

  audio_stream_proc_if #(.DATA_W(DW)) cif ();

  audio_stream_proc #(.DATA_W(DW), .DEPTH(DEPTH), .ATTEN_SHIFT(1)) dut (
    .CLOCK_50   (clk),
    .reset      (rst),
    .mode       (mode),
    .codec      (cif),
    .delay_full (delay_full)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          do_rst;
    logic [1:0]    mode;
    logic [DW-1:0] in_l, in_r, exp_l, exp_r;
    logic          exp_full;
  } vec_t;

  vec_t vecs [17];

  function automatic vec_t mkv(input logic r, input logic [1:0] m,
                               input logic [DW-1:0] il, ir, el, er, input logic f);
    vec_t v;
    v.do_rst = r; v.mode = m; v.in_l = il; v.in_r = ir;
    v.exp_l = el; v.exp_r = er; v.exp_full = f;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (cif.read) begin
      checks++;
      if (cif.write) begin
        errors++;
        $display("FAIL strobe_overlap: read=%b write=%b expected write=0", cif.read, cif.write);
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_read();
    int n = 0;
    while (!cif.read && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("read_strobe_seen", 32'(cif.read), 32'd1);
    cif.read_ready = 1'b0;
  endtask

  task automatic run_sample(input logic [1:0] m, input logic [DW-1:0] l, r,
                            output logic [DW-1:0] got_l, got_r, output int lat);
    @(negedge clk);
    mode = m;
    cif.readdata_left  = l;
    cif.readdata_right = r;
    cif.read_ready     = 1'b1;
    cif.write_ready    = 1'b1;
    wait_read();
    lat = 0;
    while (!cif.write && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    got_l = cif.writedata_left;
    got_r = cif.writedata_right;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] gl, gr;
    int lat;

    cif.read_ready = 1'b0;
    cif.write_ready = 1'b0;
    cif.readdata_left = '0;
    cif.readdata_right = '0;
    repeat (3) @(negedge clk);
    chk("reset_read", 32'(cif.read), 32'd0);
    chk("reset_write", 32'(cif.write), 32'd0);
    chk("reset_wd_l", 32'(cif.writedata_left), 32'd0);
    chk("reset_wd_r", 32'(cif.writedata_right), 32'd0);
    chk("reset_full", 32'(delay_full), 32'd0);
    rst = 1'b0;

    vecs[0]  = mkv(1, 2'd0, 24'h000100, 24'h000200, 24'h000100, 24'h000200, 0);
    vecs[1]  = mkv(0, 2'd1, 24'h123456, 24'h654321, 24'h654321, 24'h123456, 0);
    vecs[2]  = mkv(0, 2'd2, 24'h000004, 24'hFFFFFE, 24'h000001, 24'h000001, 0);
    vecs[3]  = mkv(0, 2'd2, 24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF, 1);
    vecs[4]  = mkv(0, 2'd2, 24'h800000, 24'h7FFFFF, 24'hFFFFFF, 24'hFFFFFF, 1);
    vecs[5]  = mkv(1, 2'd3, 24'h000010, 24'h000020, 24'h000010, 24'h000020, 0);
    vecs[6]  = mkv(0, 2'd3, 24'h000020, 24'h000040, 24'h000020, 24'h000040, 0);
    vecs[7]  = mkv(0, 2'd3, 24'h000030, 24'h000060, 24'h000030, 24'h000060, 0);
    vecs[8]  = mkv(0, 2'd3, 24'h000040, 24'h000080, 24'h000040, 24'h000080, 1);
    vecs[9]  = mkv(0, 2'd3, 24'h000050, 24'h0000A0, 24'h000058, 24'h0000B0, 1);
    vecs[10] = mkv(0, 2'd3, 24'h000060, 24'h0000C0, 24'h000070, 24'h0000E0, 1);
    vecs[11] = mkv(1, 2'd3, 24'h7FFFFF, 24'h800000, 24'h7FFFFF, 24'h800000, 0);
    vecs[12] = mkv(0, 2'd3, 24'h7FFFFF, 24'h800000, 24'h7FFFFF, 24'h800000, 0);
    vecs[13] = mkv(0, 2'd3, 24'h7FFFFF, 24'h800000, 24'h7FFFFF, 24'h800000, 0);
    vecs[14] = mkv(0, 2'd3, 24'h7FFFFF, 24'h800000, 24'h7FFFFF, 24'h800000, 1);
    vecs[15] = mkv(0, 2'd3, 24'h7FFFFF, 24'h800000, E_OVF_L, E_OVF_R, 1);
    vecs[16] = mkv(0, 2'd0, 24'hFEDCBA, 24'h000001, 24'hFEDCBA, 24'h000001, 1);

    for (int i = 0; i < 17; i++) begin
      if (vecs[i].do_rst) do_reset();
      run_sample(vecs[i].mode, vecs[i].in_l, vecs[i].in_r, gl, gr, lat);
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'd2);
      chk($sformatf("v%0d_out_l", i), 32'(gl), 32'(vecs[i].exp_l));
      chk($sformatf("v%0d_out_r", i), 32'(gr), 32'(vecs[i].exp_r));
      chk($sformatf("v%0d_full", i), 32'(delay_full), 32'(vecs[i].exp_full));
    end

    // Codec back-pressure: hold in S_WRITE with data stable.
    @(negedge clk);
    mode = 2'd0;
    cif.readdata_left  = 24'hABCDEF;
    cif.readdata_right = 24'h13579B;
    cif.read_ready     = 1'b1;
    cif.write_ready    = 1'b1;
    wait_read();
    cif.write_ready = 1'b0;
    @(negedge clk);
    repeat (5) begin
      @(negedge clk);
      chk("stall_write_low", 32'(cif.write), 32'd0);
      chk("stall_read_low", 32'(cif.read), 32'd0);
      chk("stall_hold_l", 32'(cif.writedata_left), 32'h00ABCDEF);
      chk("stall_hold_r", 32'(cif.writedata_right), 32'h0013579B);
    end
    cif.write_ready = 1'b1;
    @(negedge clk);
    chk("stall_release_write", 32'(cif.write), 32'd1);
    chk("stall_release_l", 32'(cif.writedata_left), 32'h00ABCDEF);
    @(negedge clk);
    chk("stall_single_pulse", 32'(cif.write), 32'd0);

    // Reset while a write is pending.
    @(negedge clk);
    mode = 2'd3;
    cif.readdata_left  = 24'h111111;
    cif.readdata_right = 24'h222222;
    cif.read_ready     = 1'b1;
    cif.write_ready    = 1'b1;
    wait_read();
    cif.write_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("prereset_full", 32'(delay_full), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_write_read", 32'({cif.read, cif.write}), 32'd0);
    chk("rst_full_cleared", 32'(delay_full), 32'd0);
    rst = 1'b0;
    cif.write_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("rst_write_dropped", 32'(cif.write), 32'd0);
    end

    for (int k = 1; k <= 5; k++) begin
      logic [DW-1:0] il, ir, el, er;
      il = DW'(k * 24'h000100);
      ir = DW'(k * 24'h000300);
      el = (k == 5) ? 24'h000580 : il;
      er = (k == 5) ? 24'h001080 : ir;
      run_sample(2'd3, il, ir, gl, gr, lat);
      chk($sformatf("post_rst%0d_out_l", k), 32'(gl), 32'(el));
      chk($sformatf("post_rst%0d_out_r", k), 32'(gr), 32'(er));
      chk($sformatf("post_rst%0d_full", k), 32'(delay_full), (k >= 4) ? 32'd1 : 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
